// File: rtl/vga_sync_gen.sv
// VGA timing generator (640x480@60 by default): pixel divider, x/y counters, and registered, blanked colour and syncs.
// Optional feature macro VGA_TEST_PATTERN_EN adds a test_mode input that shows eight vertical colour bars.
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_tick,
  output logic       video_on,
  output logic       frame_start,
  input  logic [2:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb_out
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HS_START = H_ACTIVE + H_FP;
  localparam int   VS_START = V_ACTIVE + V_FP;
  localparam logic SYNC_ON  = (SYNC_POL != 0);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  function automatic logic in_window(input logic [9:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  function automatic logic sync_level(input logic active);
    return active ? SYNC_ON : ~SYNC_ON;
  endfunction

  // ---- stage p0: pixel-rate divider ----
  logic [3:0] div_cnt_p0;
  logic       tick_p0;

  assign tick_p0 = (div_cnt_p0 == 4'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          div_cnt_p0 <= '0;
    else if (tick_p0) div_cnt_p0 <= '0;
    else              div_cnt_p0 <= div_cnt_p0 + 4'd1;
  end

  // ---- stage p1: pixel coordinates, held for the whole pixel period ----
  logic x_last, y_last;

  assign x_last = (x == 10'(H_TOTAL - 1));
  assign y_last = (y == 10'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick_p0;
      frame_start <= tick_p0 && x_last && y_last;
      if (tick_p0) begin
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

  // Held low while in reset so the blanking flag reads inactive until timing starts.
  assign video_on = !rst && in_window(x, 0, H_ACTIVE) && in_window(y, 0, V_ACTIVE);

  logic [2:0] pix_rgb_p1;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_p1;

  // Bar index x/80 from comparisons against the bar boundaries.
  always_comb begin
    bar_p1 = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (int'(x) >= i * 80) bar_p1 = 3'(i);
    end
  end

  assign pix_rgb_p1 = test_mode ? bar_p1 : rgb_in;
`else
  assign pix_rgb_p1 = rgb_in;
`endif

  // ---- stage p2: connector outputs, one pixel behind x/y ----
  logic       hsync_p2, vsync_p2;
  logic [2:0] rgb_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_p2 <= ~SYNC_ON;
      vsync_p2 <= ~SYNC_ON;
      rgb_p2   <= 3'b000;
    end else if (tick_p0) begin
      hsync_p2 <= sync_level(in_window(x, HS_START, HS_START + H_SYNC));
      vsync_p2 <= sync_level(in_window(y, VS_START, VS_START + V_SYNC));
      rgb_p2   <= video_on ? pix_rgb_p1 : 3'b000;
    end
  end

  assign hsync   = hsync_p2;
  assign vsync   = vsync_p2;
  assign rgb_out = rgb_p2;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a scaled-down raster: checkpoint table, per-clock reference model, reset sequences, random colours.
module tb_vga_sync_gen;
  localparam int CLK_DIV  = 4;
  localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACTIVE = 24, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int SYNC_POL = 0;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;
  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rgb_in = 3'b000;
  logic [9:0] x, y;
  logic       pix_tick, video_on, frame_start, hsync, vsync;
  logic [2:0] rgb_out;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  vga_sync_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(SYNC_POL)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .pix_tick(pix_tick), .video_on(video_on),
    .frame_start(frame_start), .rgb_in(rgb_in),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       tick;
    logic       fs;
    logic       vid;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } obs_t;

  typedef struct {
    int c; int x; int y; int tick; int hs; int vs; int fs;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int c = 0;
  logic [2:0] cur_col = 3'b000, prev_col = 3'b000;
  bit const_mode = 1'b1;
  int ticks_in_frame = 0, corner_hits = 0, hs_run = 0, vs_run = 0;
  bit seen_fs = 1'b0;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (clk %0d after release)", name, act, exp, c);
    end
  endtask

  // Reference: after cc clocks the raster has advanced floor(cc/CLK_DIV) pixels;
  // connector outputs describe the previous pixel.
  function automatic obs_t model(input bit in_rst, input int cc, input logic [2:0] pcol);
    obs_t e;
    int k, p, q, qx, qy;
    e = '0;
    e.hs = ~SYNC_ON;
    e.vs = ~SYNC_ON;
    if (in_rst) return e;
    k = cc / CLK_DIV;
    p = k % FRAME;
    e.x = 10'(p % HT);
    e.y = 10'(p / HT);
    e.tick = (cc > 0) && (cc % CLK_DIV == 0);
    e.fs = e.tick && (k > 0) && (p == 0);
    e.vid = (p % HT < H_ACTIVE) && (p / HT < V_ACTIVE);
    if (k > 0) begin
      q = (k - 1) % FRAME;
      qx = q % HT;
      qy = q / HT;
      if (qx >= H_ACTIVE + H_FP && qx < H_ACTIVE + H_FP + H_SYNC) e.hs = SYNC_ON;
      if (qy >= V_ACTIVE + V_FP && qy < V_ACTIVE + V_FP + V_SYNC) e.vs = SYNC_ON;
      if (qx < H_ACTIVE && qy < V_ACTIVE) e.rgb = pcol;
    end
    return e;
  endfunction

  task automatic compare_all();
    obs_t a, e;
    a = '{x, y, pix_tick, frame_start, video_on, hsync, vsync, rgb_out};
    e = model(rst, c, prev_col);
    check("model", 32'(a), 32'(e));
    if (!rst) begin
      if (frame_start) begin
        if (seen_fs) begin
          check("frame_ticks", 32'(ticks_in_frame), 32'(FRAME));
          check("corner_once", 32'(corner_hits), 32'd1);
        end
        seen_fs = 1'b1;
        ticks_in_frame = 0;
        corner_hits = 0;
      end
      if (pix_tick) begin
        ticks_in_frame++;
        if (x == 10'(H_ACTIVE - 1) && y == 10'(V_ACTIVE - 1)) corner_hits++;
      end
      if (hsync == SYNC_ON) hs_run++;
      else if (hs_run > 0) begin
        check("hsync_width", 32'(hs_run), 32'(H_SYNC * CLK_DIV));
        hs_run = 0;
      end
      if (vsync == SYNC_ON) vs_run++;
      else if (vs_run > 0) begin
        check("vsync_width", 32'(vs_run), 32'(V_SYNC * HT * CLK_DIV));
        vs_run = 0;
      end
    end
  endtask

  function automatic logic [2:0] next_col();
    return const_mode ? 3'b101 : 3'($urandom);
  endfunction

  task automatic clk_step();
    @(posedge clk);
    if (!rst) c++;
    @(negedge clk);
    if (!rst && c > 0 && c % CLK_DIV == 0) begin
      prev_col = cur_col;
      cur_col = next_col();
      rgb_in = cur_col;
    end
    compare_all();
  endtask

  task automatic release_rst();
    rst = 1'b0;
    c = 0;
    prev_col = 3'b000;
    cur_col = next_col();
    rgb_in = cur_col;
  endtask

  task automatic assert_rst(input int clks);
    rst = 1'b1;
    #1;
    compare_all();
    hs_run = 0;
    vs_run = 0;
    seen_fs = 1'b0;
    ticks_in_frame = 0;
    corner_hits = 0;
    repeat (clks) clk_step();
  endtask

  initial begin
    // {clk after release, x, y, pix_tick, hsync, vsync, frame_start}
    tbl.push_back('{3,    0,  0,  0, 1, 1, 0});
    tbl.push_back('{4,    1,  0,  1, 1, 1, 0});
    tbl.push_back('{8,    2,  0,  1, 1, 1, 0});
    tbl.push_back('{275,  68, 0,  0, 1, 1, 0});
    tbl.push_back('{276,  69, 0,  1, 0, 1, 0});
    tbl.push_back('{307,  76, 0,  0, 0, 1, 0});
    tbl.push_back('{308,  77, 0,  1, 1, 1, 0});
    tbl.push_back('{320,  0,  1,  1, 1, 1, 0});
    tbl.push_back('{8323, 0,  26, 0, 1, 1, 0});
    tbl.push_back('{8324, 1,  26, 1, 1, 0, 0});
    tbl.push_back('{8960, 0,  28, 1, 1, 0, 0});
    tbl.push_back('{8964, 1,  28, 1, 1, 1, 0});
    tbl.push_back('{9919, 79, 30, 0, 1, 1, 0});
    tbl.push_back('{9920, 0,  0,  1, 1, 1, 1});

    repeat (3) @(negedge clk);
    compare_all();
    check("reset_hsync", 32'(hsync), 32'd1);
    check("reset_rgb", 32'(rgb_out), 32'd0);

    // Constant rgb_in=101 through the first frame, checked at table checkpoints.
    const_mode = 1'b1;
    release_rst();
    foreach (tbl[i]) begin
      while (c < tbl[i].c) clk_step();
      check("tbl_x", 32'(x), 32'(tbl[i].x));
      check("tbl_y", 32'(y), 32'(tbl[i].y));
      check("tbl_tick", 32'(pix_tick), 32'(tbl[i].tick));
      check("tbl_hsync", 32'(hsync), 32'(tbl[i].hs));
      check("tbl_vsync", 32'(vsync), 32'(tbl[i].vs));
      check("tbl_fs", 32'(frame_start), 32'(tbl[i].fs));
    end

    // Second full frame with random colours, then reset at x=30,y=10.
    const_mode = 1'b0;
    while (c < (2 * FRAME + 10 * HT + 30) * CLK_DIV) clk_step();
    check("pre_rst_x", 32'(x), 32'd30);
    check("pre_rst_y", 32'(y), 32'd10);
    rst = 1'b1;
    #1;
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'(rgb_out), 32'd0);
    assert_rst(3);
    release_rst();
    repeat (3) begin
      clk_step();
      check("rel_no_tick", 32'(pix_tick), 32'd0);
    end
    clk_step();
    check("rel_first_tick", 32'(pix_tick), 32'd1);
    check("rel_no_fs", 32'(frame_start), 32'd0);
    check("rel_x", 32'(x), 32'd1);

    // Random run lengths, colour modes and reset pulses.
    for (int it = 0; it < 6; it++) begin
      const_mode = bit'($urandom_range(0, 1));
      repeat ($urandom_range(300, 3000)) clk_step();
      assert_rst($urandom_range(1, 4));
      release_rst();
    end
    repeat (200) clk_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
